// File: rtl/mxv_frame_tx_if.sv
// Handshake and data bundle between the frame transmitter, its result FIFO and the UART.
interface mxv_frame_tx_if #(
  parameter int unsigned RES_W = 16
);
  logic             start;
  logic [7:0]       len;
  logic [RES_W-1:0] res_data;
  logic             res_empty;
  logic             pop_result;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             busy;
  logic             done;

  // Frame transmitter side
  modport master (
    input  start, len, res_data, res_empty, tx_ready,
    output pop_result, tx_data, tx_valid, busy, done
  );

  // Environment side: requester, result FIFO and UART
  modport slave (
    output start, len, res_data, res_empty, tx_ready,
    input  pop_result, tx_data, tx_valid, busy, done
  );
endinterface

// File: rtl/mxv_frame_tx.sv
// mxv_frame_tx: serialises one response frame "FE_cc_ll_<payload>_EF" as uppercase
// ASCII hex to a UART transmitter, pulling result values from a show-ahead FIFO.
// Optional build macro MXV_TX_CHECKSUM_EN adds "_ss" (mod-256 sum of the payload
// bytes) between the payload and the "_EF" trailer.
module mxv_frame_tx #(
  parameter int unsigned RES_W    = 16,
  parameter logic [7:0]  RESP_CMD = 8'h05
) (
  input logic            clk,
  input logic            rst,
  mxv_frame_tx_if.master bus
);
  localparam int unsigned NIB_N = RES_W / 4;
  localparam int unsigned IDX_W = 3;
  localparam logic [7:0]  CH_F  = 8'h46;
  localparam logic [7:0]  CH_E  = 8'h45;
  localparam logic [7:0]  CH_US = 8'h5F;
`ifdef MXV_TX_CHECKSUM_EN
  localparam int unsigned BYTE_N = RES_W / 8;
`endif

  typedef enum logic [3:0] {
    IDLE, HDR, CMD, SEP_A, LEN, SEP_B, PAYLOAD, SEP_C, TRAIL, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [RES_W-1:0] val_q, val_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             pop_q, pop_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef MXV_TX_CHECKSUM_EN
  logic [7:0]       sum_q, sum_d;
`endif
  logic             adv_c;
  logic             fetch_c;

  function automatic logic [7:0] to_hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign adv_c = tx_valid_q & bus.tx_ready;

  // Next character, frame sequencing and FIFO value fetch
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    val_d      = val_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    pop_d      = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef MXV_TX_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    fetch_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = HDR;
          idx_d      = '0;
          len_d      = bus.len;
          cnt_d      = '0;
`ifdef MXV_TX_CHECKSUM_EN
          sum_d      = '0;
`endif
          tx_data_d  = CH_F;
          tx_valid_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      HDR: begin
        if (adv_c) begin
          if (idx_q == 3'd2) begin
            state_d   = CMD;
            idx_d     = '0;
            tx_data_d = to_hex(RESP_CMD[7:4]);
          end else begin
            idx_d     = idx_q + 3'd1;
            tx_data_d = (idx_q == 3'd0) ? CH_E : CH_US;
          end
        end
      end
      CMD: begin
        if (adv_c) begin
          if (idx_q == 3'd1) begin
            state_d   = SEP_A;
            idx_d     = '0;
            tx_data_d = CH_US;
          end else begin
            idx_d     = 3'd1;
            tx_data_d = to_hex(RESP_CMD[3:0]);
          end
        end
      end
      SEP_A: begin
        if (adv_c) begin
          state_d   = LEN;
          idx_d     = '0;
          tx_data_d = to_hex(len_q[7:4]);
        end
      end
      LEN: begin
        if (adv_c) begin
          if (idx_q == 3'd1) begin
            state_d   = SEP_B;
            idx_d     = '0;
            tx_data_d = CH_US;
          end else begin
            idx_d     = 3'd1;
            tx_data_d = to_hex(len_q[3:0]);
          end
        end
      end
      SEP_B: begin
        if (adv_c) begin
          if (len_q == 8'd0) begin
            state_d   = SEP_C;
            idx_d     = '0;
            tx_data_d = CH_US;
          end else begin
            fetch_c = 1'b1;
          end
        end
      end
      PAYLOAD: begin
        // tx_valid low here means the FIFO was empty when a value was needed
        if (!tx_valid_q) begin
          fetch_c = 1'b1;
        end else if (adv_c) begin
          if (idx_q == IDX_W'(NIB_N - 1)) begin
            if (cnt_q == len_q) begin
              state_d   = SEP_C;
              idx_d     = '0;
              tx_data_d = CH_US;
            end else begin
              fetch_c = 1'b1;
            end
          end else begin
            idx_d     = idx_q + 3'd1;
            tx_data_d = to_hex(val_q[RES_W-1 -: 4]);
            val_d     = val_q << 4;
          end
        end
      end
      SEP_C: begin
        if (adv_c) begin
`ifdef MXV_TX_CHECKSUM_EN
          case (idx_q)
            3'd0: begin idx_d = 3'd1; tx_data_d = to_hex(sum_q[7:4]); end
            3'd1: begin idx_d = 3'd2; tx_data_d = to_hex(sum_q[3:0]); end
            3'd2: begin idx_d = 3'd3; tx_data_d = CH_US; end
            default: begin
              state_d   = TRAIL;
              idx_d     = '0;
              tx_data_d = CH_E;
            end
          endcase
`else
          state_d   = TRAIL;
          idx_d     = '0;
          tx_data_d = CH_E;
`endif
        end
      end
      TRAIL: begin
        if (adv_c) begin
          if (idx_q == 3'd0) begin
            idx_d     = 3'd1;
            tx_data_d = CH_F;
          end else begin
            state_d    = DONE;
            idx_d      = '0;
            tx_data_d  = '0;
            tx_valid_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Start of a value: latch the FIFO head and pop it, or stall while empty
    if (fetch_c) begin
      state_d = PAYLOAD;
      idx_d   = '0;
      if (!bus.res_empty) begin
        val_d      = bus.res_data << 4;
        pop_d      = 1'b1;
        tx_valid_d = 1'b1;
        tx_data_d  = to_hex(bus.res_data[RES_W-1 -: 4]);
        cnt_d      = cnt_q + 8'd1;
`ifdef MXV_TX_CHECKSUM_EN
        for (int unsigned b = 0; b < BYTE_N; b++) begin
          sum_d = sum_d + bus.res_data[b*8 +: 8];
        end
`endif
      end else begin
        tx_valid_d = 1'b0;
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      val_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      pop_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef MXV_TX_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      val_q      <= val_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      pop_q      <= pop_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef MXV_TX_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign bus.tx_data    = tx_data_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.pop_result = pop_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_mxv_frame_tx.sv
// Testbench for mxv_frame_tx: vector table, randomized frames against a string-level
// frame model, plus hand sequences for FIFO gaps, ignored starts and mid-frame reset.
module tb_mxv_frame_tx;
  localparam int unsigned RES_W = 16;

  logic clk = 1'b0;
  logic rst;
  mxv_frame_tx_if #(.RES_W(RES_W)) bus ();

  mxv_frame_tx #(.RES_W(RES_W), .RESP_CMD(8'h05)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  // Show-ahead result FIFO model
  logic [15:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign bus.res_empty = (rd_ptr == wr_ptr);
  assign bus.res_data  = mem[rd_ptr[9:0]];
  always @(posedge clk) if (bus.pop_result && rd_ptr != wr_ptr) rd_ptr <= rd_ptr + 1;

  task automatic push(input logic [15:0] v);
    mem[wr_ptr[9:0]] = v;
    wr_ptr++;
  endtask

  // UART ready: always ready or random back-pressure
  bit rdy_rnd = 1'b0;
  always @(negedge clk) bus.tx_ready = rdy_rnd ? 1'($urandom_range(0, 1)) : 1'b1;

  // Bus monitor
  byte        got[$];
  int         pop_cnt = 0;
  int         done_cnt = 0;
  int         cyc = 0;
  int         last_xfer_cyc = -10;
  logic [7:0] last_char = 8'h00;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  bit         gap_active = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("stall_hold", {bus.tx_valid, bus.tx_data}, {1'b1, prev_data});
      if (gap_active) check("gap_quiet", {bus.tx_valid, bus.pop_result}, 2'b00);
      if (bus.tx_valid) check("busy_with_valid", bus.busy, 1'b1);
      if (bus.tx_valid && bus.tx_ready) begin
        got.push_back(bus.tx_data);
        last_xfer_cyc = cyc;
        last_char = bus.tx_data;
      end
      if (bus.pop_result) begin
        pop_cnt++;
        check("pop_not_empty", rd_ptr != wr_ptr, 1'b1);
      end
      if (bus.done) begin
        done_cnt++;
        check("done_after_last_F", {last_xfer_cyc == cyc - 1, last_char}, {1'b1, 8'h46});
      end
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_data  = bus.tx_data;
    end
    cyc++;
  end

  // Frame model built from the textual frame layout
  function automatic string hx2(input int b);
    string h = "0123456789ABCDEF";
    int hi = (b >> 4) & 15;
    int lo = b & 15;
    return {h.substr(hi, hi), h.substr(lo, lo)};
  endfunction

  function automatic string model_frame(input int n, input logic [15:0] v[$]);
    string s;
    int sum = 0;
    s = {"FE_", hx2(5), "_", hx2(n), "_"};
    for (int i = 0; i < n; i++) begin
      s = {s, hx2(int'(v[i][15:8])), hx2(int'(v[i][7:0]))};
      sum += int'(v[i][15:8]) + int'(v[i][7:0]);
    end
`ifdef MXV_TX_CHECKSUM_EN
    s = {s, "_", hx2(sum % 256)};
`endif
    return {s, "_EF"};
  endfunction

  function automatic string got_str();
    string s = "";
    foreach (got[i]) s = $sformatf("%s%c", s, got[i]);
    return s;
  endfunction

  task automatic wait_done();
    int k = 0;
    while (!bus.done && k < 4000) begin
      @(negedge clk);
      k++;
    end
    check("done_timeout", bus.done, 1'b1);
  endtask

  // Launch one frame; gap_at >= 0 holds the FIFO empty for 10 cycles before that value
  task automatic run_frame(input int n, input logic [15:0] v[$], input int gap_at, input bit rnd);
    got.delete();
    pop_cnt  = 0;
    done_cnt = 0;
    rdy_rnd  = rnd;
    for (int i = 0; i < n; i++) if (gap_at < 0 || i < gap_at) push(v[i]);
    @(negedge clk);
    bus.len   = 8'(n);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.len   = 8'hA5;
    check("start_to_F", {bus.tx_valid, bus.busy, bus.tx_data}, {1'b1, 1'b1, 8'h46});
    if (gap_at >= 0) begin
      int k = 0;
      while (!(pop_cnt == gap_at && !bus.tx_valid) && k < 2000) begin
        @(negedge clk);
        k++;
      end
      check("gap_stall_reached", {pop_cnt == gap_at, bus.tx_valid}, {1'b1, 1'b0});
      gap_active = 1'b1;
      repeat (10) @(negedge clk);
      gap_active = 1'b0;
      for (int i = gap_at; i < n; i++) push(v[i]);
    end
    wait_done();
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    int          n;
    logic [15:0] v0, v1, v2;
    string       exp;
  } vec_t;

  vec_t tbl[4];

  initial begin
    logic [15:0] q[$];
    int          sz, pc, n;

`ifdef MXV_TX_CHECKSUM_EN
    tbl[0] = '{3, 16'h0004, 16'h0012, 16'h00AB, "FE_05_03_0004001200AB_C1_EF"};
    tbl[1] = '{0, 16'h0000, 16'h0000, 16'h0000, "FE_05_00__00_EF"};
    tbl[2] = '{1, 16'hFFFF, 16'h0000, 16'h0000, "FE_05_01_FFFF_FE_EF"};
    tbl[3] = '{2, 16'h1234, 16'hABCD, 16'h0000, "FE_05_02_1234ABCD_BE_EF"};
`else
    tbl[0] = '{3, 16'h0004, 16'h0012, 16'h00AB, "FE_05_03_0004001200AB_EF"};
    tbl[1] = '{0, 16'h0000, 16'h0000, 16'h0000, "FE_05_00__EF"};
    tbl[2] = '{1, 16'hFFFF, 16'h0000, 16'h0000, "FE_05_01_FFFF_EF"};
    tbl[3] = '{2, 16'h1234, 16'hABCD, 16'h0000, "FE_05_02_1234ABCD_EF"};
`endif

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.len   = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.tx_valid, bus.tx_data, bus.pop_result, bus.busy, bus.done}, '0);
    rst = 1'b0;
    @(negedge clk);

    // Vector table
    for (int t = 0; t < 4; t++) begin
      q = '{tbl[t].v0, tbl[t].v1, tbl[t].v2};
      run_frame(tbl[t].n, q, -1, 1'b0);
      check_str($sformatf("table%0d_frame", t), got_str(), tbl[t].exp);
      check_str($sformatf("table%0d_model", t), got_str(), model_frame(tbl[t].n, q));
      check($sformatf("table%0d_pops", t), pop_cnt, tbl[t].n);
      check($sformatf("table%0d_done", t), done_cnt, 1);
    end

    // Random values and lengths under random back-pressure
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(0, 5);
      q.delete();
      for (int i = 0; i < 5; i++) q.push_back(16'($urandom));
      run_frame(n, q, -1, 1'b1);
      check_str($sformatf("rand%0d_frame", t), got_str(), model_frame(n, q));
      check($sformatf("rand%0d_pops", t), pop_cnt, n);
      check($sformatf("rand%0d_done", t), done_cnt, 1);
    end

    // FIFO empty before the second value
    q = '{16'h0004, 16'h0012, 16'h00AB};
    run_frame(3, q, 1, 1'b0);
    check_str("gap_frame", got_str(), model_frame(3, q));
    check("gap_pops", pop_cnt, 3);

    // Starts while busy and in the done cycle are ignored
    got.delete();
    pop_cnt  = 0;
    done_cnt = 0;
    rdy_rnd  = 1'b0;
    q = '{16'hBEEF, 16'h0A0B};
    push(q[0]);
    push(q[1]);
    bus.len   = 8'd2;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    bus.len   = 8'd9;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("idle_after_done", {bus.tx_valid, bus.busy}, 2'b00);
      @(negedge clk);
    end
    check_str("ignored_start_frame", got_str(), model_frame(2, q));
    check("ignored_start_done", done_cnt, 1);
    check("ignored_start_pops", pop_cnt, 2);

    // Reset during the payload aborts the frame
    got.delete();
    pop_cnt = 0;
    q = '{16'h1111, 16'h2222, 16'h3333};
    foreach (q[i]) push(q[i]);
    bus.len   = 8'd3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    begin
      int k = 0;
      while (pop_cnt < 1 && k < 200) begin
        @(negedge clk);
        k++;
      end
      check("reach_payload", pop_cnt >= 1, 1'b1);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midframe_reset_outputs",
          {bus.tx_valid, bus.tx_data, bus.pop_result, bus.busy, bus.done}, '0);
    rst = 1'b0;
    sz = got.size();
    pc = pop_cnt;
    repeat (20) @(negedge clk);
    check("no_resume_chars", got.size(), sz);
    check("no_resume_pops", pop_cnt, pc);
    check("no_resume_busy", bus.busy, 1'b0);
    wr_ptr = rd_ptr;
    q = '{16'h00C3, 16'h5A00};
    run_frame(2, q, -1, 1'b1);
    check_str("after_reset_frame", got_str(), model_frame(2, q));
    check("after_reset_done", done_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
